// File: rtl/clock_divider_pkg.sv
// Shared definitions for the clock divider sequencing controller.
// Holds the controller state encoding, default parameter values and a
// small helper used to size the shared timer.
package clock_divider_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_LOW = 3'd1,
        ST_APPLY    = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_RST_CYCLES   = 2;
    localparam int DEF_SETTLE_EDGES = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_edge_detect.sv
// Edge detector for the fed-back divided clock.
// Ports:
//   clk_in - system clock
//   clr    - synchronous clear of the history register (reset or re-arm)
//   sig    - divided clock, already in the clk_in domain
//   rise   - sig went 0 -> 1 relative to the previous cycle
//   fall   - sig went 1 -> 0 relative to the previous cycle
module clk_edge_detect (
    input  logic clk_in,
    input  logic clr,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic prev;

    always_ff @(posedge clk_in) begin
        if (clr) begin
            prev <= 1'b0;
        end else begin
            prev <= sig;
        end
    end

    assign rise = ~prev & sig;
    assign fall = prev & ~sig;

endmodule

// File: rtl/clock_divider_ctrl.sv
// Sequencing controller sitting between the config/pin interface and the
// clock divider. Accepts a new scale over valid/ready, waits for the divided
// clock's low phase, pulses the divider reset while presenting the new scale,
// then counts output rising edges before reporting completion.
// Ports:
//   clk_in, rst              - system clock, synchronous active-high reset
//   req_valid/req_ready      - request handshake
//   req_scale, req_force     - requested scale; force skips the low-phase wait
//   div_nrst, div_scale      - drive the divider
//   div_clk_out              - divider output fed back (clk_in domain)
//   cur_scale                - scale currently active in the divider
//   busy, done               - not idle / one-cycle completion pulse
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a request
// WAIT_LOW  | waiting for a falling edge of div_clk_out
// APPLY     | divider held in reset with the new scale presented
// SETTLE    | counting rising edges of the restarted divided clock
// DONE      | one-cycle completion pulse
module clock_divider_ctrl
    import clock_divider_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int SETTLE_EDGES = DEF_SETTLE_EDGES
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_scale,
    input  logic             req_force,
    output logic             req_ready,
    output logic             div_nrst,
    output logic [WIDTH-1:0] div_scale,
    input  logic             div_clk_out,
    output logic [WIDTH-1:0] cur_scale,
    output logic             busy,
    output logic             done
);

    localparam int CNT_MAX = max_int(RST_CYCLES, SETTLE_EDGES);
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] new_scale_q, new_scale_d;
    logic [WIDTH-1:0] div_scale_q, div_scale_d;
    logic [WIDTH-1:0] cur_scale_q, cur_scale_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             div_nrst_q, div_nrst_d;
    logic             edge_rearm;
    logic             rise, fall;

    clk_edge_detect u_edge (
        .clk_in (clk_in),
        .clr    (rst | edge_rearm),
        .sig    (div_clk_out),
        .rise   (rise),
        .fall   (fall)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            new_scale_q <= '0;
            div_scale_q <= '0;
            cur_scale_q <= '0;
            cnt_q       <= '0;
            div_nrst_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            new_scale_q <= new_scale_d;
            div_scale_q <= div_scale_d;
            cur_scale_q <= cur_scale_d;
            cnt_q       <= cnt_d;
            div_nrst_q  <= div_nrst_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        new_scale_d = new_scale_q;
        div_scale_d = div_scale_q;
        cur_scale_d = cur_scale_q;
        cnt_d       = cnt_q;
        edge_rearm  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    new_scale_d = req_scale;
                    if (req_scale == cur_scale_q) begin
                        state_d = ST_DONE;
                    end else if (req_force || (cur_scale_q == '0)) begin
                        // In bypass the fed-back clock is clk_in itself, so
                        // there is no low phase worth waiting for.
                        state_d     = ST_APPLY;
                        div_scale_d = req_scale;
                        cnt_d       = CW'(RST_CYCLES - 1);
                    end else begin
                        state_d = ST_WAIT_LOW;
                    end
                end
            end
            ST_WAIT_LOW: begin
                if (fall) begin
                    state_d     = ST_APPLY;
                    div_scale_d = new_scale_q;
                    cnt_d       = CW'(RST_CYCLES - 1);
                end
            end
            ST_APPLY: begin
                if (cnt_q == '0) begin
                    cur_scale_d = new_scale_q;
                    // Divider output restarts from low; forget the stale level.
                    edge_rearm  = 1'b1;
                    if (new_scale_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SETTLE;
                        cnt_d   = CW'(SETTLE_EDGES);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_SETTLE: begin
                if (rise) begin
                    if (cnt_q <= CW'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered so the divider stays in reset for as long as rst is high.
        div_nrst_d = (state_d != ST_APPLY);
    end

    assign req_ready = (state_q == ST_IDLE) & ~rst;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign div_nrst  = div_nrst_q;
    assign div_scale = div_scale_q;
    assign cur_scale = cur_scale_q;

endmodule

// File: tb/tb_clock_divider_ctrl.sv
module tb_clock_divider_ctrl;

    localparam int W      = 8;
    localparam int RSTC   = 2;
    localparam int SETTLE = 2;

    logic         clk_in = 1'b0;
    logic         rst;
    logic         req_valid;
    logic [W-1:0] req_scale;
    logic         req_force;
    logic         req_ready;
    logic         div_nrst;
    logic [W-1:0] div_scale;
    logic         div_clk_out;
    logic [W-1:0] cur_scale;
    logic         busy;
    logic         done;

    always #5 clk_in = ~clk_in;

    clock_divider_ctrl #(.WIDTH(W), .RST_CYCLES(RSTC), .SETTLE_EDGES(SETTLE)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_scale   (req_scale),
        .req_force   (req_force),
        .req_ready   (req_ready),
        .div_nrst    (div_nrst),
        .div_scale   (div_scale),
        .div_clk_out (div_clk_out),
        .cur_scale   (cur_scale),
        .busy        (busy),
        .done        (done)
    );

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Toy divider: held low in reset, toggles every cycle in bypass, otherwise
    // toggles every max(scale-1,1) cycles (scale 5 -> half-period 4).
    logic mout = 1'b0;
    int   mcnt = 0;
    logic freeze = 1'b0;
    always @(posedge clk_in) begin
        int half;
        half = (div_scale > 1) ? int'(div_scale) - 1 : 1;
        if (!div_nrst) begin
            mout <= 1'b0;
            mcnt <= 0;
        end else if (div_scale == 0) begin
            mout <= ~mout;
        end else if (mcnt >= half - 1) begin
            mcnt <= 0;
            mout <= ~mout;
        end else begin
            mcnt <= mcnt + 1;
        end
    end
    assign div_clk_out = freeze ? 1'b1 : mout;

    // kind: 0 same scale, 1 immediate apply, 2 wait for low phase
    typedef struct {
        int           t;
        logic [W-1:0] scale;
        int           kind;
    } req_t;
    req_t sbq[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Monitor / scoreboard: derives expected timing from the request rules and
    // the observed divider output, and compares every cycle.
    int           exp_apply = -1;
    int           exp_done  = -1;
    int           rise_cnt  = 0;
    logic [W-1:0] sb_cur    = '0;
    logic         prev_out  = 1'b0;
    logic         rst_prev  = 1'b0;

    always @(negedge clk_in) begin
        int   c;
        req_t e;
        logic in_apply;
        c = cyc;
        if (rst || rst_prev) begin
            if (rst) chk("ready_in_rst", req_ready, 0);
            if (rst_prev) begin
                chk("rst_nrst", div_nrst, 0);
                chk("rst_div_scale", div_scale, 0);
                chk("rst_cur_scale", cur_scale, 0);
                chk("rst_done", done, 0);
                chk("rst_busy", busy, 0);
            end
            if (rst) begin
                sbq.delete();
                exp_apply = -1;
                exp_done  = -1;
                rise_cnt  = 0;
                sb_cur    = '0;
            end
        end else if (sbq.size() == 0 || c <= sbq[0].t) begin
            chk("idle_nrst", div_nrst, 1);
            chk("idle_ready", req_ready, 1);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_cur_scale", cur_scale, sb_cur);
            chk("idle_div_scale", div_scale, sb_cur);
        end else begin
            e = sbq[0];
            if (e.kind == 0) exp_done = e.t + 1;
            else if (e.kind == 1 && exp_apply < 0) exp_apply = e.t + 1;
            else if (e.kind == 2 && exp_apply < 0 && prev_out && !div_clk_out) exp_apply = c + 1;

            if (exp_apply >= 0 && exp_done < 0 && c >= exp_apply + RSTC) begin
                if (e.scale == 0) begin
                    exp_done = exp_apply + RSTC;
                end else if (div_clk_out && (c == exp_apply + RSTC || !prev_out)) begin
                    rise_cnt++;
                    if (rise_cnt == SETTLE) exp_done = c + 1;
                end
            end

            in_apply = (exp_apply >= 0) && (c >= exp_apply) && (c < exp_apply + RSTC);
            chk("nrst", div_nrst, !in_apply);
            chk("busy", busy, 1);
            chk("ready_busy", req_ready, 0);
            chk("div_scale", div_scale, (exp_apply >= 0 && c >= exp_apply) ? e.scale : sb_cur);
            chk("cur_scale", cur_scale, (exp_apply >= 0 && c >= exp_apply + RSTC) ? e.scale : sb_cur);
            chk("done", done, (c == exp_done));
            if (c == exp_done) begin
                sb_cur = e.scale;
                void'(sbq.pop_front());
                exp_apply = -1;
                exp_done  = -1;
                rise_cnt  = 0;
            end
        end
        prev_out = div_clk_out;
        rst_prev = rst;
    end

    logic [W-1:0] model_cur = '0;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] s, input logic f);
        int k;
        if (s == model_cur) k = 0;
        else if (f || model_cur == 0) k = 1;
        else k = 2;
        req_valid = 1'b1;
        req_scale = s;
        req_force = f;
        sbq.push_back('{cyc, s, k});
        model_cur = s;
    endtask

    task automatic send(input logic [W-1:0] s, input logic f);
        issue(s, f);
        step();
        req_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        req_valid = 1'b0;
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
        model_cur = '0;
        step();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL completion_timeout cycle=%0d actual=pending required=done within %0d", cyc, budget);
            do_reset(2);
        end
    endtask

    task automatic wait_out_high(input int budget);
        int n;
        n = 0;
        while (div_clk_out !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (div_clk_out !== 1'b1) begin
            failures++;
            $display("FAIL div_clk_high_timeout cycle=%0d actual=%0d required=1", cyc, div_clk_out);
        end
    endtask

    initial begin
        logic [W-1:0] s;
        logic         f;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_scale = '0;
        req_force = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();

        // From bypass to scale 5
        send(8'd5, 1'b0);
        wait_idle(200);
        step();

        // Glitch-free change while divided clock is high
        wait_out_high(50);
        send(8'd3, 1'b0);
        wait_idle(200);

        // Same-scale request
        send(8'd3, 1'b0);
        wait_idle(20);

        // Forced return to bypass while divided clock is high
        send(8'd6, 1'b0);
        wait_idle(200);
        wait_out_high(50);
        send(8'd0, 1'b1);
        wait_idle(50);

        // Randomized sequence
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 4)) step();
            s = W'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) s = model_cur;
            f = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1 && model_cur != 0) wait_out_high(50);
            send(s, f);
            wait_idle(400);
        end

        // Busy and abort: hung divider, held request, then reset
        if (model_cur == 8'd6) begin
            send(8'd2, 1'b0);
            wait_idle(200);
        end
        send(8'd6, 1'b0);
        wait_idle(200);
        freeze = 1'b1;
        step();
        issue(8'd4, 1'b0);
        step();
        req_scale = 8'd1;
        repeat (6) step();
        do_reset(2);
        freeze = 1'b0;
        step();

        // Recovery from bypass
        send(8'd7, 1'b0);
        wait_idle(200);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
